// File: rtl/rfb_pkg.sv
// Shared sizing defaults, types and the component-width helper for the RFB column scheduler.
package rfb_pkg;

  localparam int DEF_NUM_CHANNELS = 2;
  localparam int DEF_SCAN_RATE    = 32;
  localparam int DEF_NUM_ROWS     = 64;
  localparam int DEF_DATA_SIZE    = 1;
  localparam int DEF_RGB_RES      = 9;

  typedef logic [$clog2(DEF_SCAN_RATE)-1:0] col_num_t;
  typedef logic [DEF_RGB_RES-1:0]           pixel_t;
  typedef pixel_t [DEF_NUM_ROWS-1:0]        column_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    WAIT_LAST = 2'd2
  } state_t;

  // Mono pixels carry one bit for all components; colour pixels carry DATA_SIZE/3 per component.
  function automatic int comp_bits(input int data_size);
    return (data_size == 1) ? 1 : data_size / 3;
  endfunction

endpackage

// File: rtl/rfb_pixel_expand.sv
// Combinational widening of one stored pixel (DATA_SIZE bits) to a display pixel (RGB_RES bits).
module rfb_pixel_expand
  import rfb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int RGB_RES   = DEF_RGB_RES
) (
  input  logic [DATA_SIZE-1:0] pixel_raw,
  output logic [RGB_RES-1:0]   pixel_rgb
);

  if (DATA_SIZE == 1) begin : g_mono
    assign pixel_rgb = {RGB_RES{pixel_raw[0]}};
  end else begin : g_rgb
    localparam int IN_W  = comp_bits(DATA_SIZE);
    localparam int OUT_W = RGB_RES / 3;
    // MSB-first repetition of each component, cut off at the LSB end
    for (genvar c = 0; c < 3; c++) begin : g_comp
      for (genvar j = 0; j < OUT_W; j++) begin : g_bit
        assign pixel_rgb[c*OUT_W + OUT_W - 1 - j] = pixel_raw[c*IN_W + IN_W - 1 - (j % IN_W)];
      end
    end
  end

endmodule

// File: rtl/rfb_column_scheduler.sv
// Snapshots one RFB column per channel and presents the channels one at a time to the HUB75 driver.
// Build option RFB_RADIUS_SWAP_EN: channel k is displayed at the radius of channel NUM_CHANNELS-1-k.
module rfb_column_scheduler
  import rfb_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int SCAN_RATE    = DEF_SCAN_RATE,
  parameter int NUM_ROWS     = DEF_NUM_ROWS,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int RGB_RES      = DEF_RGB_RES,
  localparam int COL_W  = $clog2(SCAN_RATE),
  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_CHANNELS*COL_W-1:0]           radii_in,
  input  logic [NUM_CHANNELS*NUM_ROWS*DATA_SIZE-1:0] rfb_cols_in,
  input  logic                                    hub75_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NUM_CHANNELS*NUM_ROWS*RGB_RES-1:0] columns,
  output logic [COL_W-1:0]                        col_num,
  output logic [CHAN_W-1:0]                       out_chan
);

  // state     | meaning
  // IDLE      | in_ready high, waiting for a snapshot
  // EMIT      | presenting channel chan until out_ready
  // WAIT_LAST | all channels sent, waiting for end-of-row (live or latched)

  localparam int SEG    = NUM_ROWS * RGB_RES;
  localparam int COLS_W = NUM_CHANNELS * SEG;
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHANNELS - 1);

`ifdef RFB_RADIUS_SWAP_EN
  localparam bit RADIUS_SWAP = 1'b1;
`else
  localparam bit RADIUS_SWAP = 1'b0;
`endif

  function automatic int rad_src(input int k);
    return RADIUS_SWAP ? (NUM_CHANNELS - 1 - k) : k;
  endfunction

  state_t                        state;
  logic [CHAN_W-1:0]             chan;
  logic [CHAN_W-1:0]             next_chan;
  logic                          last_seen;
  logic [COLS_W-1:0]             expanded;
  logic [COLS_W-1:0]             snap;
  logic [COLS_W-1:0]             first_cols;
  logic [COLS_W-1:0]             emit_cols;
  logic [NUM_CHANNELS*COL_W-1:0] radii_q;
  logic [COL_W-1:0]              first_radius;
  logic [COL_W-1:0]              emit_radius;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      rfb_pixel_expand #(
        .DATA_SIZE(DATA_SIZE),
        .RGB_RES  (RGB_RES)
      ) u_expand (
        .pixel_raw(rfb_cols_in[(k*NUM_ROWS + r)*DATA_SIZE +: DATA_SIZE]),
        .pixel_rgb(expanded[(k*NUM_ROWS + r)*RGB_RES +: RGB_RES])
      );
    end
  end

  // First beat comes straight from the inputs; later beats from the snapshot.
  always_comb begin
    next_chan    = chan + CHAN_W'(1);
    first_cols   = '0;
    first_cols[SEG-1:0] = expanded[SEG-1:0];
    first_radius = radii_in[rad_src(0)*COL_W +: COL_W];
    emit_cols    = '0;
    emit_radius  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (k == int'(next_chan)) begin
        emit_cols[k*SEG +: SEG] = snap[k*SEG +: SEG];
        emit_radius = radii_q[rad_src(k)*COL_W +: COL_W];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      chan      <= '0;
      last_seen <= 1'b0;
      snap      <= '0;
      radii_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      columns   <= '0;
      col_num   <= '0;
      out_chan  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state     <= EMIT;
            chan      <= '0;
            snap      <= expanded;
            radii_q   <= radii_in;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            columns   <= first_cols;
            col_num   <= first_radius;
            out_chan  <= '0;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        EMIT: begin
          if (hub75_last) last_seen <= 1'b1;
          if (out_ready) begin
            if (chan == LAST_CHAN) begin
              state     <= WAIT_LAST;
              out_valid <= 1'b0;
              columns   <= '0;
            end else begin
              chan      <= next_chan;
              columns   <= emit_cols;
              col_num   <= emit_radius;
              out_chan  <= next_chan;
            end
          end
        end
        WAIT_LAST: begin
          if (last_seen || hub75_last) begin
            state     <= IDLE;
            last_seen <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfb_column_scheduler.sv
// Randomized bench for rfb_column_scheduler: a mono 2-channel instance and a 6->9 bit 4-channel instance.
module tb_rfb_column_scheduler;

`ifdef RFB_RADIUS_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // mono instance: 2 channels x 64 rows, 1 -> 9 bits
  logic          m_rst_n, m_in_valid, m_in_ready, m_last, m_out_valid, m_out_ready;
  logic [9:0]    m_radii;
  logic [127:0]  m_cols_in;
  logic [1151:0] m_columns;
  logic [4:0]    m_col_num;
  logic [0:0]    m_out_chan;

  // colour instance: 4 channels x 4 rows, 6 -> 9 bits
  logic          g_rst_n, g_in_valid, g_in_ready, g_last, g_out_valid, g_out_ready;
  logic [19:0]   g_radii;
  logic [95:0]   g_cols_in;
  logic [143:0]  g_columns;
  logic [4:0]    g_col_num;
  logic [1:0]    g_out_chan;

  rfb_column_scheduler #(
    .NUM_CHANNELS(2), .SCAN_RATE(32), .NUM_ROWS(64), .DATA_SIZE(1), .RGB_RES(9)
  ) u_mono (
    .clk_in(clk), .rst_n_in(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .radii_in(m_radii), .rfb_cols_in(m_cols_in), .hub75_last(m_last),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .columns(m_columns),
    .col_num(m_col_num), .out_chan(m_out_chan)
  );

  rfb_column_scheduler #(
    .NUM_CHANNELS(4), .SCAN_RATE(32), .NUM_ROWS(4), .DATA_SIZE(6), .RGB_RES(9)
  ) u_rgb (
    .clk_in(clk), .rst_n_in(g_rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .radii_in(g_radii), .rfb_cols_in(g_cols_in), .hub75_last(g_last),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .columns(g_columns),
    .col_num(g_col_num), .out_chan(g_out_chan)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int src_idx(input int k, input int n);
    return SWAP ? (n - 1 - k) : k;
  endfunction

  // repeat a k-bit value MSB-first until m bits are filled, dropping excess low bits
  function automatic int rep_bits(input int v, input int k, input int m);
    int acc;
    int n;
    acc = 0;
    n   = 0;
    while (n < m) begin
      acc = (acc << k) | v;
      n  += k;
    end
    return acc >> (n - m);
  endfunction

  function automatic int expand_px(input int px, input int ds, input int rgb);
    int o;
    int kb;
    int mb;
    if (ds == 1) return ((px & 1) != 0) ? ((1 << rgb) - 1) : 0;
    kb = ds / 3;
    mb = rgb / 3;
    o  = 0;
    for (int c = 0; c < 3; c++)
      o |= rep_bits((px >> (c*kb)) & ((1 << kb) - 1), kb, mb) << (c*mb);
    return o;
  endfunction

  function automatic logic [575:0] mono_seg(input logic [63:0] bits);
    logic [575:0] s;
    s = '0;
    for (int r = 0; r < 64; r++) s[r*9 +: 9] = 9'(expand_px(int'(bits[r]), 1, 9));
    return s;
  endfunction

  function automatic logic [143:0] rgb_beat(input logic [95:0] raw, input int idx);
    logic [143:0] s;
    s = '0;
    for (int r = 0; r < 4; r++)
      s[(idx*4 + r)*9 +: 9] = 9'(expand_px(int'(raw[(idx*4 + r)*6 +: 6]), 6, 9));
    return s;
  endfunction

  // mode 0: end-of-row arrives late in WAIT_LAST; 1: with final accept; 2: in first EMIT cycle
  task automatic mono_frame(input logic [9:0] radii, input logic [127:0] raw, input int stall,
                            input int hold_first, input int mode, input bit hold_valid);
    int idx;
    bit rdy;
    bit got;
    m_radii    = radii;
    m_cols_in  = raw;
    m_in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = m_in_ready;
      tick();
    end
    check_eq("m_accept", got, 1);
    if (!hold_valid) m_in_valid = 1'b0;
    m_radii   = 10'($urandom);
    m_cols_in = {$urandom, $urandom, $urandom, $urandom};
    idx = 0;
    for (int cyc = 0; cyc < 300 && idx < 2; cyc++) begin
      rdy = (cyc >= hold_first) && ($urandom_range(99) >= stall);
      m_out_ready = rdy;
      m_last = (mode == 2 && cyc == 0) || (mode == 1 && idx == 1 && rdy);
      check_eq("m_out_valid", m_out_valid, 1);
      check_eq("m_in_ready_busy", m_in_ready, 0);
      check_eq("m_col_num", m_col_num, radii[src_idx(idx, 2)*5 +: 5]);
      check_eq("m_out_chan", m_out_chan, idx);
      for (int k = 0; k < 2; k++)
        check_eq("m_columns", m_columns[k*576 +: 576], (k == idx) ? mono_seg(raw[k*64 +: 64]) : '0);
      tick();
      if (rdy) idx++;
    end
    m_out_ready = 1'b0;
    m_last      = 1'b0;
    m_in_valid  = 1'b0;
    check_eq("m_beats_done", idx, 2);
    check_eq("m_wait_valid", m_out_valid, 0);
    check_eq("m_wait_cols_zero", (m_columns == '0), 1);
    check_eq("m_wait_in_ready", m_in_ready, 0);
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        check_eq("m_wait_hold", m_in_ready, 0);
      end
      m_last = 1'b1;
      tick();
      m_last = 1'b0;
    end else begin
      tick();
    end
    check_eq("m_back_idle", m_in_ready, 1);
  endtask

  task automatic rgb_frame(input logic [19:0] radii, input logic [95:0] raw, input int stall);
    int idx;
    bit rdy;
    bit got;
    g_radii    = radii;
    g_cols_in  = raw;
    g_in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = g_in_ready;
      tick();
    end
    check_eq("g_accept", got, 1);
    g_in_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 4; cyc++) begin
      rdy = ($urandom_range(99) >= stall);
      g_out_ready = rdy;
      check_eq("g_out_valid", g_out_valid, 1);
      check_eq("g_col_num", g_col_num, radii[src_idx(idx, 4)*5 +: 5]);
      check_eq("g_out_chan", g_out_chan, idx);
      check_eq("g_columns", g_columns, rgb_beat(raw, idx));
      tick();
      if (rdy) idx++;
    end
    g_out_ready = 1'b0;
    check_eq("g_beats_done", idx, 4);
    check_eq("g_wait_valid", g_out_valid, 0);
    g_last = 1'b1;
    tick();
    g_last = 1'b0;
    check_eq("g_back_idle", g_in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] raw_g;
    m_rst_n = 1'b0; m_in_valid = 1'b0; m_radii = '0; m_cols_in = '0; m_last = 1'b0; m_out_ready = 1'b0;
    g_rst_n = 1'b0; g_in_valid = 1'b0; g_radii = '0; g_cols_in = '0; g_last = 1'b0; g_out_ready = 1'b0;
    tick();
    tick();
    check_eq("m_rst_in_ready", m_in_ready, 0);
    check_eq("m_rst_out_valid", m_out_valid, 0);
    check_eq("g_rst_in_ready", g_in_ready, 0);
    m_rst_n = 1'b1;
    g_rst_n = 1'b1;
    tick();
    check_eq("m_post_rst_in_ready", m_in_ready, 1);
    check_eq("m_post_rst_out_valid", m_out_valid, 0);
    check_eq("m_post_rst_cols_zero", (m_columns == '0), 1);
    check_eq("m_post_rst_col_num", m_col_num, 0);
    check_eq("m_post_rst_out_chan", m_out_chan, 0);
    check_eq("g_post_rst_in_ready", g_in_ready, 1);

    // radii {3,17}, ch0 all ones, ch1 alternating
    mono_frame({5'd17, 5'd3}, {{32{2'b10}}, {64{1'b1}}}, 0, 0, 1, 1'b0);
    // five stalled cycles on the first beat with a new snapshot offered throughout
    mono_frame({5'd17, 5'd3}, {{32{2'b10}}, {64{1'b1}}}, 0, 5, 0, 1'b1);
    mono_frame(10'($urandom), {$urandom, $urandom, $urandom, $urandom}, 30, 0, 2, 1'b0);
    for (int i = 0; i < 12; i++)
      mono_frame(10'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 int'($urandom_range(60)), 0, int'($urandom_range(2)), 1'($urandom));

    // colour path: ch0 row0 = RGB {10,01,11}, then reset while channel 1 is on the bus
    raw_g = {$urandom, $urandom, $urandom};
    raw_g[5:0] = 6'b10_01_11;
    g_radii    = 20'($urandom);
    g_cols_in  = raw_g;
    g_in_valid = 1'b1;
    tick();
    g_in_valid = 1'b0;
    check_eq("g_px_6to9", g_columns[8:0], 9'b101_010_111);
    check_eq("g_first_chan", g_out_chan, 0);
    g_out_ready = 1'b1;
    tick();
    g_out_ready = 1'b0;
    check_eq("g_mid_chan", g_out_chan, 1);
    check_eq("g_mid_valid", g_out_valid, 1);
    #2;
    g_rst_n = 1'b0;
    #1;
    check_eq("g_async_valid", g_out_valid, 0);
    check_eq("g_async_cols_zero", (g_columns == '0), 1);
    check_eq("g_async_in_ready", g_in_ready, 0);
    tick();
    g_rst_n = 1'b1;
    tick();
    check_eq("g_rerst_in_ready", g_in_ready, 1);
    check_eq("g_rerst_valid", g_out_valid, 0);
    rgb_frame(20'($urandom), {$urandom, $urandom, $urandom}, 0);
    for (int i = 0; i < 6; i++)
      rgb_frame(20'($urandom), {$urandom, $urandom, $urandom}, int'($urandom_range(50)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
